// File: rtl/half_adder_pkg.sv
// Shared types and golden function for half-adder checking logic.
package half_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;

  // Reference half-adder behaviour, packed as {carry, sum}.
  function automatic logic [1:0] ha_expected(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/half_adder_golden.sv
// Combinational golden half adder, reusable by any adder checker.
module half_adder_golden
  import half_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic sum,
  output logic c_out
);

  // Reference outputs straight from the shared golden function.
  always_comb begin
    {c_out, sum} = ha_expected(x, y);
  end

endmodule

// File: rtl/half_adder_response_checker.sv
// On-chip self-test: walks the four half-adder input vectors, holds each
// for HOLD_CYCLES, compares the DUT response in the last cycle of the hold
// window and reports pass / saturating error count / per-vector fail mask.
module half_adder_response_checker
  import half_adder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             x,
  output logic             y,
  input  logic             sum,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_VECTORS - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             accept;
  logic             sample;
  logic             last;
  logic             exp_sum;
  logic             exp_c_out;
  logic             mismatch;

  half_adder_golden u_golden (
    .x     (x),
    .y     (y),
    .sum   (exp_sum),
    .c_out (exp_c_out)
  );

  assign mismatch = ({c_out, sum} != {exp_c_out, exp_sum});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          sample = 1'b1;
          if (idx == IDX_LAST) begin
            last       = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector sequencing, hold counter and result accumulation. x/y are kept
  // in their own registers so they stay at the last vector (1,1) in DONE
  // while idx stops advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (accept) begin
      cnt       <= '0;
      idx       <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (state == RUN) begin
      if (sample) begin
        cnt <= '0;
        if (mismatch) begin
          fail_vec[idx] <= 1'b1;
          if (err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
          end
        end
        if (!last) begin
          idx    <= idx + 2'd1;
          {x, y} <= idx + 2'd1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Status decoded from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = done && (err_count == '0);
  end

endmodule

// File: tb/tb_half_adder_response_checker.sv
module tb_half_adder_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;

  logic       x1, y1, sum1, c1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fv1;
  logic       x2, y2, sum2, c2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [3:0] fv2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int errc;
    int fvec;
    int pas;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Half adder under test for dut1: 0 correct, 1 sum stuck 0, 2 swapped, 3 inverted.
  always_comb begin
    case (mode)
      2'd0:    begin sum1 = x1 ^ y1;    c1 = x1 & y1;    end
      2'd1:    begin sum1 = 1'b0;       c1 = x1 & y1;    end
      2'd2:    begin sum1 = x1 & y1;    c1 = x1 ^ y1;    end
      default: begin sum1 = ~(x1 ^ y1); c1 = ~(x1 & y1); end
    endcase
  end

  // dut2 always sees a fully inverted half adder.
  always_comb begin
    sum2 = ~(x2 ^ y2);
    c2   = ~(x2 & y2);
  end

  half_adder_response_checker #(.HOLD_CYCLES(4), .ERR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x1), .y(y1), .sum(sum1), .c_out(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  half_adder_response_checker #(.HOLD_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .x(x2), .y(y2), .sum(sum2), .c_out(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected result on each rising edge of done.
  logic done1_q = 1'b0;
  logic done2_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done1 && !done1_q) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        check("dut1_done_cycle", cyc, e.cyc);
        check("dut1_err_count", int'(err1), e.errc);
        check("dut1_fail_vec", int'(fv1), e.fvec);
        check("dut1_pass", int'(pass1), e.pas);
        check("dut1_busy_at_done", int'(busy1), 0);
      end
    end
    done1_q = done1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2 && !done2_q) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_done", 1, 0);
      end else begin
        e = q2.pop_front();
        check("dut2_done_cycle", cyc, e.cyc);
        check("dut2_err_count", int'(err2), e.errc);
        check("dut2_fail_vec", int'(fv2), e.fvec);
        check("dut2_pass", int'(pass2), e.pas);
      end
    end
    done2_q = done2;
  end

  // Pulse start across one edge; optionally push expectations for each DUT.
  task automatic pulse_start(input bit p1, input int e_err, input int e_fv,
                             input int e_pass, input bit p2);
    exp_t e;
    @(posedge clk);
    #1 start = 1'b1;
    if (p1) begin
      e.errc = e_err; e.fvec = e_fv; e.pas = e_pass; e.cyc = cyc + 1 + 16;
      q1.push_back(e);
    end
    if (p2) begin
      e.errc = 3; e.fvec = 4'b1111; e.pas = 0; e.cyc = cyc + 1 + 8;
      q2.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("run_completed_in_budget", q1.size() + q2.size(), 0);
    q1.delete();
    q2.delete();
    @(posedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_x", int'(x1), 0);
    check("reset_y", int'(y1), 0);
    check("reset_busy", int'(busy1), 0);
    check("reset_done", int'(done1), 0);
    check("reset_pass", int'(pass1), 0);
    check("reset_err_count", int'(err1), 0);
    check("reset_fail_vec", int'(fv1), 0);
    @(negedge clk) rst = 1'b0;

    // Correct adder: full pass; busy and vector 0 visible right after start edge.
    mode = 2'd0;
    pulse_start(1'b1, 0, 4'b0000, 1, 1'b1);
    check("busy_after_start", int'(busy1), 1);
    check("vec0_xy", int'({x1, y1}), 0);
    wait_idle(60);

    // sum stuck at 0.
    mode = 2'd1;
    pulse_start(1'b1, 2, 4'b0110, 0, 1'b1);
    wait_idle(60);

    // Both outputs inverted on the ERR_W=3 instance: count reaches 4.
    mode = 2'd3;
    pulse_start(1'b1, 4, 4'b1111, 0, 1'b1);
    wait_idle(60);

    // start re-pulsed during RUN is ignored by both instances.
    mode = 2'd0;
    pulse_start(1'b1, 0, 4'b0000, 1, 1'b1);
    repeat (2) @(posedge clk);
    pulse_start(1'b0, 0, 0, 0, 1'b0);
    wait_idle(60);

    // Swapped outputs, then results held in DONE, then restart from DONE.
    mode = 2'd2;
    pulse_start(1'b1, 3, 4'b1110, 0, 1'b1);
    wait_idle(60);
    repeat (3) @(posedge clk);
    #1;
    check("done_level_held", int'(done1), 1);
    check("done_xy_hold_11", int'({x1, y1}), 3);
    check("done_err_stable", int'(err1), 3);
    mode = 2'd0;
    pulse_start(1'b1, 0, 4'b0000, 1, 1'b1);
    check("restart_done_cleared", int'(done1), 0);
    check("restart_err_cleared", int'(err1), 0);
    check("restart_fv_cleared", int'(fv1), 0);
    check("restart_busy", int'(busy1), 1);
    check("restart_xy", int'({x1, y1}), 0);
    wait_idle(60);

    // Reset during vector 2 of a failing run.
    mode = 2'd1;
    pulse_start(1'b1, 2, 4'b0110, 0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    check("mid_run_vec2_xy", int'({x1, y1}), 2);
    check("mid_run_err_before_reset", int'(err1), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_x", int'(x1), 0);
    check("async_reset_y", int'(y1), 0);
    check("async_reset_busy", int'(busy1), 0);
    check("async_reset_err", int'(err1), 0);
    check("async_reset_fv", int'(fv1), 0);
    check("async_reset_done2", int'(done2), 0);
    q1.delete();
    q2.delete();
    #10 rst = 1'b0;

    // Fresh run after reset.
    mode = 2'd0;
    pulse_start(1'b1, 0, 4'b0000, 1, 1'b1);
    wait_idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
